// File: rtl/countdown_timer_pkg.sv
// Shared state encodings for the countdown timer FSM.
package countdown_timer_pkg;

    localparam int STATE_W = 2;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_RUN    = 2'd1;
    localparam state_t ST_EXPIRE = 2'd2;

endpackage

// File: rtl/countdown_datapath.sv
// Reload register plus down-count register with zero/one detection.
module countdown_datapath #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_ld,
    input  logic [WIDTH-1:0] i_ld_val,
    input  logic             i_dec,
    input  logic             i_reload_en,
    output logic [WIDTH-1:0] o_count,
    output logic             o_zero,
    output logic             o_one,
    output logic             o_reload_zero
);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_reload;
    logic             w_zero;

    assign w_zero        = (r_count == '0);
    assign o_zero        = w_zero;
    assign o_one         = (r_count == WIDTH'(1));
    assign o_reload_zero = (r_reload == '0);
    assign o_count       = r_count;

    // Decrement is guarded by the zero detect so the count can never wrap.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_count  <= '0;
            r_reload <= '0;
        end else if (i_ld) begin
            r_reload <= i_ld_val;
            r_count  <= i_ld_val;
        end else if (i_reload_en) begin
            r_count <= r_reload;
        end else if (i_dec && !w_zero) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter/timer with start/done handshake and optional auto-reload.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             start,
    input  logic             abort,
    output logic [WIDTH-1:0] count_out,
    output logic             busy,
    output logic             done
);

    state_t           r_state;
    state_t           w_state_n;
    logic             r_busy;
    logic             r_done;
    logic             w_ld;
    logic             w_dec;
    logic             w_reload_en;
    logic [WIDTH-1:0] w_count;
    logic [WIDTH-1:0] w_start_cnt;
    logic             w_zero;
    logic             w_one;
    logic             w_reload_zero;

    countdown_datapath #(.WIDTH(WIDTH)) u_dp (
        .clock         (clock),
        .reset         (reset),
        .i_ld          (w_ld),
        .i_ld_val      (load_value),
        .i_dec         (w_dec),
        .i_reload_en   (w_reload_en),
        .o_count       (w_count),
        .o_zero        (w_zero),
        .o_one         (w_one),
        .o_reload_zero (w_reload_zero)
    );

    // A start coincident with load must see the value being loaded this cycle.
    assign w_start_cnt = load ? load_value : w_count;

    always_comb begin
        w_state_n   = r_state;
        w_ld        = 1'b0;
        w_dec       = 1'b0;
        w_reload_en = 1'b0;
        if (abort) begin
            w_state_n = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_ld = load;
                    if (start)
                        w_state_n = (w_start_cnt != '0) ? ST_RUN : ST_EXPIRE;
                end
                ST_RUN: begin
                    if (enable) begin
                        w_dec = 1'b1;
                        if (w_one || w_zero)
                            w_state_n = ST_EXPIRE;
                    end
                end
                ST_EXPIRE: begin
                    if (AUTO_RELOAD) begin
                        w_reload_en = 1'b1;
                        w_state_n   = w_reload_zero ? ST_EXPIRE : ST_RUN;
                    end else begin
                        w_state_n = ST_IDLE;
                    end
                end
                default: w_state_n = ST_IDLE;
            endcase
        end
    end

    // busy/done are registered from the next state so they align with the state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_busy  <= (w_state_n != ST_IDLE);
            r_done  <= (w_state_n == ST_EXPIRE);
        end
    end

    assign count_out = w_count;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
